alu_iter_mul: RTL and testbench

//  Iterative 32x32 unsigned multiplier acting as the initiator on the ALU

---
 rtl/alu_iter_mul.sv | 156 +++++++++++++++
 tb/tb_alu_iter_mul.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/alu_iter_mul.sv
// ---------------------------------------------------------------------------
// alu_iter_mul
//   Iterative unsigned multiplier that borrows an external ALU for all of its
//   arithmetic. One ALU operation is issued per cycle: an add accumulates
//   the (possibly zero) shifted multiplicand, then a logical right shift
//   consumes one multiplier bit. The result is the low WIDTH bits of a*b.
//
//   Optional feature macro: MUL_EARLY_EXIT_EN
//     defined   - stop as soon as the shifted multiplier reaches zero
//                 (ALU zero flag during SHIFT), or after WIDTH steps.
//     undefined - always run WIDTH add/shift steps (fixed latency 2*WIDTH+1).
//
//   Ports
//     clk      in   rising-edge clock
//     rst      in   synchronous, active-high reset
//     start    in   request, sampled only in IDLE
//     a, b     in   multiplicand / multiplier, latched when start is accepted
//     busy     out  high while an operation is in flight (ADD/SHIFT/DONE)
//     done     out  one-cycle pulse; product valid from this cycle
//     product  out  low WIDTH bits of a*b, held until the next result
//     alu_a    out  ALU operand A
//     alu_b    out  ALU operand B
//     alu_op   out  ALU operation code
//     alu_res  in   ALU result (combinational, same cycle)
//     alu_zero in   ALU zero flag (combinational, same cycle)
// ---------------------------------------------------------------------------
module alu_iter_mul #(
  parameter int         WIDTH   = 32,
  parameter logic [2:0] OP_ADD  = 3'b010,
  parameter logic [2:0] OP_SRL  = 3'b101,
  parameter logic [2:0] OP_IDLE = 3'b000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_product;
  logic [CW-1:0]    r_cnt;

  logic             w_last;
  logic             w_term;

  assign w_last = (r_cnt == CW'(WIDTH - 1));

`ifdef MUL_EARLY_EXIT_EN
  // In SHIFT the ALU result is the remaining multiplier; once it is zero no
  // further add can change the accumulator.
  assign w_term = w_last | alu_zero;
`else
  logic w_unused_zero;
  assign w_unused_zero = alu_zero;
  assign w_term        = w_last;
`endif

  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);
  assign product = r_product;

  // ALU drive and next state. ALU operands depend only on registered state
  // so there is no loop through the external combinational ALU.
  always_comb begin
    w_state_next = r_state;
    alu_a        = '0;
    alu_b        = '0;
    alu_op       = OP_IDLE;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_ADD;
        end
      end
      S_ADD: begin
        alu_a        = r_acc;
        alu_b        = r_mplier[0] ? r_mcand : '0;
        alu_op       = OP_ADD;
        w_state_next = S_SHIFT;
      end
      S_SHIFT: begin
        alu_a        = r_mplier;
        alu_b        = WIDTH'(1);
        alu_op       = OP_SRL;
        w_state_next = w_term ? S_DONE : S_ADD;
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_product <= '0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand  <= a;
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        S_ADD: begin
          r_acc <= alu_res;
        end
        S_SHIFT: begin
          r_mplier <= alu_res;
          // Multiplicand doubling is internal wiring; its MSB falls off.
          r_mcand  <= r_mcand << 1;
          if (w_term) begin
            r_product <= r_acc;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter_mul.sv
module tb_alu_iter_mul;

  localparam int         W       = 32;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SRL  = 3'b101;
  localparam logic [2:0] OP_IDLE = 3'b000;
  localparam int         TMO     = 200;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  a, b;
  logic          busy, done;
  logic [W-1:0]  product, alu_a, alu_b, alu_res;
  logic [2:0]    alu_op;
  logic          alu_zero;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] p;
    int           inj;
    bit           sid;
  } vec_t;

  typedef struct {
    logic [W-1:0] p;
    int           lat;
  } exp_t;

  vec_t vecs[10];
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_iter_mul #(.WIDTH(W), .OP_ADD(OP_ADD), .OP_SRL(OP_SRL), .OP_IDLE(OP_IDLE)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_res(alu_res), .alu_zero(alu_zero)
  );

  // Datapath ALU stand-in: combinational add / logical right shift.
  always_comb begin
    alu_res = '0;
    case (alu_op)
      OP_ADD:  alu_res = alu_a + alu_b;
      OP_SRL:  alu_res = alu_a >> alu_b[4:0];
      default: alu_res = '0;
    endcase
  end
  assign alu_zero = (alu_res == '0);

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic int exp_lat(input logic [W-1:0] mb);
    int n;
`ifdef MUL_EARLY_EXIT_EN
    n = 1;
    while (n < W && (mb >> n) != '0) n++;
`else
    n = W;
`endif
    return 2 * n + 1;
  endfunction

  task automatic run_txn(input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [W-1:0] vp, input int inj, input bit sid);
    logic [W-1:0] m_mcand, m_mplier, m_acc, exp_b;
    exp_t e;
    int   c;
    bit   seen;
    bit   trace_ok;
    @(negedge clk);
    start = 1'b1; a = va; b = vb;
    sb.push_back('{vp, exp_lat(vb)});
    @(posedge clk); #1;
    start = 1'b0;
    m_mcand = va; m_mplier = vb; m_acc = '0;
    trace_ok = 1'b1; seen = 1'b0; c = 1;
    while (c <= TMO) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (!busy) trace_ok = 1'b0;
      if (c % 2 == 1) begin
        exp_b = m_mplier[0] ? m_mcand : '0;
        if (alu_op !== OP_ADD || alu_a !== m_acc || alu_b !== exp_b) trace_ok = 1'b0;
        m_acc = m_acc + exp_b;
      end else begin
        if (alu_op !== OP_SRL || alu_a !== m_mplier || alu_b !== 32'd1) trace_ok = 1'b0;
        m_mplier = m_mplier >> 1;
        m_mcand  = m_mcand << 1;
      end
      if (c == inj)     begin start = 1'b1; a = 32'd9; b = 32'd9; end
      if (c == inj + 1) start = 1'b0;
      @(posedge clk); #1;
      c++;
    end
    e = sb.pop_front();
    checks++;
    if (seen) passes++;
    else $display("FAIL done_timeout: no done within %0d cycles", TMO);
    check("latency", c, e.lat);
    check("product", product, e.p);
    check("done_op", {29'd0, alu_op}, {29'd0, OP_IDLE});
    check("trace", {31'd0, trace_ok}, 32'd1);
    if (sid) begin start = 1'b1; a = 32'd2; b = 32'd2; end
    @(posedge clk); #1;
    start = 1'b0;
    check("idle_after", {busy, done, alu_op, alu_a | alu_b}, '0);
    check("product_hold", product, e.p);
    $display("txn a=0x%08h b=0x%08h product=0x%08h done_cycle=%0d", va, vb, product, c);
  endtask

  initial begin
    int c;
    bit bad_done;
    logic [W-1:0] prev;

    vecs[0] = '{32'd7,        32'd6,        32'h0000002A, -10, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, -10, 1'b0};
    vecs[2] = '{32'h12345678, 32'd0,        32'h00000000, -10, 1'b0};
    vecs[3] = '{32'd3,        32'd5,        32'd15,       4,   1'b1};
    vecs[4] = '{32'd9,        32'd9,        32'd81,       -10, 1'b0};
    vecs[5] = '{32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001, -10, 1'b0};
    vecs[6] = '{32'h00010000, 32'h00010000, 32'h00000000, -10, 1'b0};
    vecs[7] = '{32'h80000000, 32'd1,        32'h80000000, -10, 1'b0};
    vecs[8] = '{32'd1,        32'h80000000, 32'h80000000, -10, 1'b0};
    vecs[9] = '{32'h12345678, 32'd1,        32'h12345678, -10, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {29'd0, busy, done, 1'b0}, '0);
    check("reset_product", product, '0);
    check("reset_alu", {29'd0, alu_op} | alu_a | alu_b, '0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      run_txn(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].inj, vecs[i].sid);

    // Reset in the middle of an operation: no done, outputs back to reset.
    prev = product;
    @(negedge clk);
    start = 1'b1; a = 32'h0000FFFF; b = 32'h0000FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    bad_done = 1'b0;
    for (c = 1; c < 10; c++) begin
      if (done) bad_done = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_busy", {31'd0, busy}, '0);
    check("rst_product", product, '0);
    check("rst_alu_op", {29'd0, alu_op}, {29'd0, OP_IDLE});
    for (int k = 0; k < 80; k++) begin
      if (done || busy) bad_done = 1'b1;
      @(posedge clk); #1;
    end
    check("rst_no_done", {31'd0, bad_done}, '0);
    $display("txn reset mid-op: prior product=0x%08h now=0x%08h", prev, product);

    run_txn(32'd7, 32'd6, 32'h0000002A, -10, 1'b0);
    check("sb_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
